// File: rtl/mac_pkg.sv
// Shared types and default sizing for the FIFO-fed multiply-accumulate consumer.
package mac_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_COUNT      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mac_fifo_consumer_if.sv
// Read-side handshake between the consumer and its two operand FIFOs.
interface mac_fifo_consumer_if
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  a_empty;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  a_rden;
    logic                  b_rden;

    modport master (
        output a_rden,
        output b_rden,
        input  a_empty,
        input  b_empty,
        input  a_data,
        input  b_data
    );

    modport slave (
        input  a_rden,
        input  b_rden,
        output a_empty,
        output b_empty,
        output a_data,
        output b_data
    );

endinterface

// File: rtl/mac_unit.sv
// Unsigned multiplier feeding a wrapping accumulator register with clear and enable.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        prod_s;
    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;

    assign prod_s = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

    // Fit the full-width product to the accumulator; narrower accumulators keep the low bits.
    generate
        if (ACC_WIDTH > PW) begin : g_zext
            assign prod_ext_s = {{(ACC_WIDTH-PW){1'b0}}, prod_s};
        end else if (ACC_WIDTH == PW) begin : g_same
            assign prod_ext_s = prod_s;
        end else begin : g_trunc
            assign prod_ext_s = prod_s[ACC_WIDTH-1:0];
        end
    endgenerate

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc_d = acc_q + prod_ext_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {ACC_WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_fifo_consumer.sv
// Pops COUNT operand pairs from two FIFOs and accumulates their dot product.
module mac_fifo_consumer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int COUNT      = DEF_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    mac_fifo_consumer_if.master  fifo,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          pop_s;
    logic          acc_clr_s;
    logic          acc_en_s;

    // Next-state, counter and strobe decode; popped data is consumed one cycle later in CAPTURE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop_s     = 1'b0;
        acc_clr_s = 1'b0;
        acc_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    cnt_d     = {CW{1'b0}};
                    acc_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (!fifo.a_empty && !fifo.b_empty) begin
                    pop_s   = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    state_d = FETCH;
                end
            end
            CAPTURE: begin
                acc_en_s = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac_unit (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_s),
        .en  (acc_en_s),
        .a   (fifo.a_data),
        .b   (fifo.b_data),
        .acc (acc_out)
    );

    assign fifo.a_rden = pop_s;
    assign fifo.b_rden = pop_s;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/mac_fifo_consumer.md
MAC_FIFO_CONSUMER -- requirements
Module: mac_fifo_consumer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - DATA_WIDTH, 8, operand width of each FIFO read port
  - ACC_WIDTH, 24, accumulator width
  - COUNT, 8, operand pairs consumed per operation
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, input, 1, single clock; all state updates on rising edge
  - rst, input, 1, synchronous active-high reset
  - start, input, 1, one-cycle pulse that begins an operation
  - a_empty, input, 1, empty flag of operand-A FIFO
  - b_empty, input, 1, empty flag of operand-B FIFO
  - a_data, input, DATA_WIDTH, registered read data of A FIFO
  - b_data, input, DATA_WIDTH, registered read data of B FIFO
  - a_rden, output, 1, pop strobe to A FIFO
  - b_rden, output, 1, pop strobe to B FIFO
  - acc_out, output, ACC_WIDTH, accumulated dot product
  - busy, output, 1, high while an operation is in progress
  - done, output, 1, one-cycle completion pulse
REQ-003 Each FIFO SHALL present popped data on its data port in the cycle after the rising edge that samples its rden; the data SHALL remain stable until the next pop.

Function
REQ-004 The FSM SHALL have four states: IDLE, FETCH, CAPTURE, DONE.
REQ-005 In IDLE, start=1 SHALL clear acc_out and the pair counter, and SHALL move the FSM to FETCH on the next edge.
REQ-006 In FETCH, a_rden and b_rden SHALL both equal (!a_empty && !b_empty), decoded combinationally from state and flags.
REQ-007 In FETCH, when both FIFOs are non-empty the FSM SHALL move to CAPTURE; otherwise it SHALL stay in FETCH with both rden low.
REQ-008 The two rden outputs SHALL never differ, and SHALL be low in every state other than FETCH.
REQ-009 In CAPTURE, the block SHALL perform acc_out <= acc_out + a_data*b_data, using an unsigned 2*DATA_WIDTH product zero-extended to ACC_WIDTH and wrapping modulo 2^ACC_WIDTH.
REQ-010 In CAPTURE, the pair counter SHALL increment; when the counter equals COUNT-1 the FSM SHALL move to DONE, otherwise to FETCH.
REQ-011 Peak throughput SHALL be one pair per 2 cycles; latency from the start edge to done SHALL be 2*COUNT+1 cycles when the FIFOs never run empty.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-013 acc_out SHALL hold its final value until the next accepted start.
REQ-014 busy SHALL be 1 in FETCH, CAPTURE and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored whenever busy=1.
REQ-016 An emptied FIFO mid-operation SHALL stall the block in FETCH indefinitely, with no pop, no accumulate, and acc_out unchanged.
REQ-017 The pair counter SHALL be $clog2(COUNT+1) bits wide and SHALL never exceed COUNT-1.

Reset
REQ-018 On a rising edge with rst=1, the block SHALL enter IDLE, clear acc_out and the counter, and drive done=0 and busy=0; rden SHALL then be 0 because the FSM is in IDLE.
REQ-019 rst SHALL take priority over start and over every in-flight state, including an assertion mid-operation.

Structure
REQ-020 Package mac_pkg SHALL hold the state enum type and the default DATA_WIDTH/ACC_WIDTH/COUNT constants.
REQ-021 One sub-module, mac_unit, SHALL contain the multiplier and the accumulator register, with clear and enable inputs; the FSM and counter SHALL stay in the top level.
REQ-022 The FIFOs SHALL be external and instantiated by the parent.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
  - Preload A={1..8} and B={1..8}, pulse start -> acc_out=204, done high for one cycle at cycle 17, 8 pops per FIFO.
  - A preloaded with 8 entries, B fed one entry every 5 cycles -> block stalls in FETCH with rden=0 between entries, final acc_out correct.
  - All 16 entries 0xFF with ACC_WIDTH=16 -> acc_out=(8*65025) mod 65536=61448.
  - Assert rst during the 4th CAPTURE -> next cycle acc_out=0, busy=0, no further rden.
  - Pulse start while busy=1 -> ignored, result and pop count unchanged.
  - Perform a completed operation, then start with both FIFOs empty -> rden stays low, busy=1, acc_out=0.
